// File: rtl/platform_field_pkg.sv
// -----------------------------------------------------------------------------
// platform_pkg
// Shared constants, types and per-slot geometry helpers for the Doodle Jump
// platform field. Imported by the interface, the LFSR and the field top.
//
// Contents:
//   NUM_PLAT, PLAT_HW, PLAT_HH, SCREEN_H, LAND_WIN  - field geometry
//   LFSR_SEED, LFSR_MASK                            - Galois LFSR setup
//   coord_t                                         - 10-bit screen coordinate
//   plat_state_t                                    - sweep FSM states
//   plat_hit()   - pixel-on-platform test for one slot
//   plat_land()  - ball-lands-on-platform test for one slot
// -----------------------------------------------------------------------------
package platform_pkg;

  localparam int          NUM_PLAT  = 16;
  localparam int          PLAT_HW   = 20;
  localparam int          PLAT_HH   = 4;
  localparam int          SCREEN_H  = 480;
  localparam int          LAND_WIN  = 3;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } plat_state_t;

  // Pixel (x,y) lies inside the platform box centred at (px,py).
  // Offsets are only ever added to the smaller side of each compare, so a
  // platform near the top or left edge never underflows.
  function automatic logic plat_hit(coord_t x, coord_t y, coord_t px, coord_t py);
    logic [10:0] x11, y11, px11, py11;
    x11  = {1'b0, x};
    y11  = {1'b0, y};
    px11 = {1'b0, px};
    py11 = {1'b0, py};
    return (x11 + 11'(PLAT_HW) >= px11) && (x11 <= px11 + 11'(PLAT_HW)) &&
           (y11 + 11'(PLAT_HH) >= py11) && (y11 <= py11 + 11'(PLAT_HH));
  endfunction

  // Ball bottom edge b sits within the landing window of the platform:
  //   top edge (py - PLAT_HH) <= b <= top edge + LAND_WIN
  // rearranged so that nothing is subtracted from py. 12-bit sums keep the
  // compare exact for any 11-bit b.
  function automatic logic plat_land(coord_t bx, logic [10:0] b, coord_t px, coord_t py);
    logic [10:0] bx11, px11;
    logic [11:0] b12, py12;
    bx11 = {1'b0, bx};
    px11 = {1'b0, px};
    b12  = {1'b0, b};
    py12 = {2'b00, py};
    return (bx11 + 11'(PLAT_HW) >= px11) && (bx11 <= px11 + 11'(PLAT_HW)) &&
           (py12 <= b12 + 12'(PLAT_HH)) &&
           (b12 + 12'(PLAT_HH) <= py12 + 12'(LAND_WIN));
  endfunction

endpackage

// File: rtl/platform_field_if.sv
// -----------------------------------------------------------------------------
// platform_field_if
// Bundles every non-clock signal of platform_field.
//
// Handshake: frame_clk is a level (VGA vsync); its rising edge requests one
// update sweep. busy is high from the first sweep cycle through the DONE
// cycle; frame_done pulses for exactly one cycle (the last busy cycle).
// Requests that arrive while busy is high are dropped, not queued.
//
// Signals:
//   frame_clk, scroll_amt             - frame request and scroll distance
//   DrawX, DrawY                      - current VGA pixel
//   BallX, BallY, Ball_size           - ball position / half-size
//   platform_on, land_on              - combinational pixel/landing flags
//   busy, frame_done                  - sweep status
//   state, lfsr                       - debug view of FSM state and LFSR
//   dbg_idx -> dbg_x, dbg_y           - debug read port into the slot file
// Modports: master drives the inputs of the field, slave is the field itself.
// -----------------------------------------------------------------------------
interface platform_field_if;
  import platform_pkg::*;

  logic        frame_clk;
  logic [3:0]  scroll_amt;
  coord_t      DrawX;
  coord_t      DrawY;
  coord_t      BallX;
  coord_t      BallY;
  coord_t      Ball_size;
  logic        platform_on;
  logic        land_on;
  logic        busy;
  logic        frame_done;
  plat_state_t state;
  logic [15:0] lfsr;
  logic [3:0]  dbg_idx;
  coord_t      dbg_x;
  coord_t      dbg_y;

  modport master (
    output frame_clk, scroll_amt, DrawX, DrawY, BallX, BallY, Ball_size, dbg_idx,
    input  platform_on, land_on, busy, frame_done, state, lfsr, dbg_x, dbg_y
  );

  modport slave (
    input  frame_clk, scroll_amt, DrawX, DrawY, BallX, BallY, Ball_size, dbg_idx,
    output platform_on, land_on, busy, frame_done, state, lfsr, dbg_x, dbg_y
  );

endinterface

// File: rtl/platform_field_lfsr.sv
// -----------------------------------------------------------------------------
// plat_lfsr
// 16-bit right-shifting Galois LFSR. Advances on every clock where step_i is
// high; reset loads SEED. With a non-zero seed and a maximal-length mask it
// never reaches the all-zero lock-up state.
//
// Ports:
//   Clk, Reset   - clock, synchronous active-high reset
//   step_i       - advance one step this cycle
//   lfsr_o       - current register value
// -----------------------------------------------------------------------------
module plat_lfsr
  import platform_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED,
  parameter logic [15:0] MASK = LFSR_MASK
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        step_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (step_i) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? MASK : 16'h0000);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/platform_field.sv
// -----------------------------------------------------------------------------
// platform_field
// Live register file of the 16 platform positions. On each rising edge of
// frame_clk it sweeps all slots (one per cycle), moving every platform down by
// the latched scroll amount; a platform falling off the bottom re-enters at
// the top with the same spacing and a pseudo-random X. In parallel it drives
// the per-pixel platform_on flag and the ball landing flag combinationally.
//
// Ports:
//   Clk    - system clock
//   Reset  - synchronous active-high reset (restores the start layout)
//   bus    - platform_field_if.slave; see the interface for signal list
// -----------------------------------------------------------------------------
module platform_field
  import platform_pkg::*;
(
  input  logic           Clk,
  input  logic           Reset,
  platform_field_if.slave bus
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_PLAT - 1);

  coord_t      plat_x_q [NUM_PLAT];
  coord_t      plat_y_q [NUM_PLAT];

  logic        fsync1_q, fsync2_q, fprev_q;
  logic        frame_edge;

  plat_state_t state_q;
  logic [3:0]  idx_q;
  logic [3:0]  scr_q;
  logic        busy_q;
  logic        done_q;

  logic [15:0] lfsr;

  logic [10:0] ny_d;
  logic        wrap_d;
  coord_t      ny_wrap_d;
  coord_t      new_x_d;

  // The LFSR free-runs so the respawn X depends on when in the frame the
  // wrap happens, not just on how many wraps occurred.
  plat_lfsr #(
    .SEED (LFSR_SEED),
    .MASK (LFSR_MASK)
  ) u_lfsr (
    .Clk    (Clk),
    .Reset  (Reset),
    .step_i (1'b1),
    .lfsr_o (lfsr)
  );

  // frame_clk is asynchronous to Clk: two sync flops, then an edge detect
  // on the synced copy.
  assign frame_edge = fsync2_q & ~fprev_q;

  // Next position of the slot being swept this cycle.
  always_comb begin
    ny_d      = {1'b0, plat_y_q[idx_q]} + {7'd0, scr_q};
    wrap_d    = (ny_d >= 11'(SCREEN_H));
    ny_wrap_d = coord_t'(ny_d - 11'(SCREEN_H));
    new_x_d   = 10'd32 + {1'b0, lfsr[8:0]};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_PLAT; i++) begin
        plat_x_q[i] <= coord_t'(32 + 36 * i);
        plat_y_q[i] <= coord_t'(15 + 30 * i);
      end
      fsync1_q <= 1'b0;
      fsync2_q <= 1'b0;
      fprev_q  <= 1'b0;
      state_q  <= IDLE;
      idx_q    <= '0;
      scr_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      fsync1_q <= bus.frame_clk;
      fsync2_q <= fsync1_q;
      fprev_q  <= fsync2_q;
      done_q   <= 1'b0;

      case (state_q)
        IDLE: begin
          if (frame_edge) begin
            scr_q   <= bus.scroll_amt;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SWEEP;
          end
        end

        SWEEP: begin
          if (wrap_d) begin
            // Subtracting SCREEN_H rather than clamping to 0 keeps the
            // vertical gap to the neighbouring platforms unchanged.
            plat_y_q[idx_q] <= ny_wrap_d;
            plat_x_q[idx_q] <= new_x_d;
          end else begin
            plat_y_q[idx_q] <= coord_t'(ny_d);
          end
          idx_q <= idx_q + 4'd1;
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end

        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Pixel and landing flags: OR of the per-slot tests over the live file.
  logic [10:0] ball_bot_d;
  logic        on_d;
  logic        land_d;

  always_comb begin
    ball_bot_d = {1'b0, bus.BallY} + {1'b0, bus.Ball_size};
    on_d       = 1'b0;
    land_d     = 1'b0;
    for (int i = 0; i < NUM_PLAT; i++) begin
      on_d   = on_d   | plat_hit(bus.DrawX, bus.DrawY, plat_x_q[i], plat_y_q[i]);
      land_d = land_d | plat_land(bus.BallX, ball_bot_d, plat_x_q[i], plat_y_q[i]);
    end
  end

  assign bus.platform_on = on_d;
  assign bus.land_on     = land_d;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = done_q;
  assign bus.state       = state_q;
  assign bus.lfsr        = lfsr;
  assign bus.dbg_x       = plat_x_q[bus.dbg_idx];
  assign bus.dbg_y       = plat_y_q[bus.dbg_idx];

endmodule

// File: tb/tb_platform_field.sv
// -----------------------------------------------------------------------------
// tb_platform_field
// Directed bench for platform_field: reset layout, pixel/landing flags,
// scrolling sweeps with wrap-around, dropped mid-sweep requests and reset
// during a sweep. Expected slot positions come from a bench-side field model
// and a bench-side LFSR; they are queued and compared against the debug read
// port after each sweep.
// -----------------------------------------------------------------------------
module tb_platform_field;
  import platform_pkg::*;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  platform_field_if bus ();

  platform_field dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  logic [19:0] exp_q[$];          // {x, y} per slot
  coord_t      mx [NUM_PLAT];
  coord_t      my [NUM_PLAT];

  logic [15:0] m_lfsr;
  logic [15:0] cap_lfsr [NUM_PLAT];
  int          sw_cnt = 0;
  int          done_cnt = 0;

  // Reference LFSR and per-slot capture of the value in effect when each
  // slot is swept.
  always @(posedge Clk) begin
    if (bus.state == SWEEP) begin
      if (sw_cnt < NUM_PLAT) cap_lfsr[sw_cnt] <= m_lfsr;
      sw_cnt <= sw_cnt + 1;
    end else begin
      sw_cnt <= 0;
    end
    if (bus.frame_done === 1'b1) done_cnt <= done_cnt + 1;
    if (Reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- checker / driver tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_PLAT; i++) begin
      mx[i] = coord_t'(32 + 36 * i);
      my[i] = coord_t'(15 + 30 * i);
    end
  endtask

  task automatic push_model();
    for (int i = 0; i < NUM_PLAT; i++) exp_q.push_back({mx[i], my[i]});
  endtask

  task automatic model_frame(input logic [3:0] scr);
    int ny;
    for (int i = 0; i < NUM_PLAT; i++) begin
      ny = int'(my[i]) + int'(scr);
      if (ny >= 480) begin
        my[i] = coord_t'(ny - 480);
        mx[i] = coord_t'(32 + int'(cap_lfsr[i][8:0]));
      end else begin
        my[i] = coord_t'(ny);
      end
    end
  endtask

  task automatic verify_slots(input string tag);
    logic [19:0] e;
    for (int i = 0; i < NUM_PLAT; i++) begin
      bus.dbg_idx = 4'(i);
      #1;
      if (exp_q.size() == 0) begin
        check($sformatf("%s_queue_empty", tag), 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s_x%0d", tag, i), 32'(bus.dbg_x), 32'(e[19:10]));
        check($sformatf("%s_y%0d", tag, i), 32'(bus.dbg_y), 32'(e[9:0]));
      end
    end
  endtask

  task automatic pix(input int x, input int y, input logic exp, input string tag);
    bus.DrawX = coord_t'(x);
    bus.DrawY = coord_t'(y);
    #1;
    check(tag, 32'(bus.platform_on), 32'(exp));
  endtask

  task automatic ball(input int x, input int y, input int sz, input logic exp, input string tag);
    bus.BallX = coord_t'(x);
    bus.BallY = coord_t'(y);
    bus.Ball_size = coord_t'(sz);
    #1;
    check(tag, 32'(bus.land_on), 32'(exp));
  endtask

  // Request one frame and track busy/frame_done timing. With mid_toggle set,
  // a second request and a new scroll value are applied inside the sweep.
  task automatic run_frame(input logic [3:0] scr, input bit mid_toggle, input string tag);
    int lat, hi, d0;
    d0 = done_cnt;
    @(negedge Clk);
    bus.scroll_amt = scr;
    bus.frame_clk  = 1'b1;
    lat = 0;
    do begin
      @(negedge Clk);
      lat++;
    end while (!bus.busy && lat < 20);
    check({tag, "_busy_latency"}, 32'(lat), 32'd3);
    hi = 0;
    while (bus.busy && hi < 40) begin
      hi++;
      if (mid_toggle && hi == 4) bus.frame_clk = 1'b0;
      if (mid_toggle && hi == 8) begin
        bus.frame_clk  = 1'b1;
        bus.scroll_amt = 4'd15;
      end
      @(negedge Clk);
    end
    check({tag, "_busy_len"}, 32'(hi), 32'd17);
    repeat (30) @(negedge Clk);
    check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_idle_after"}, 32'(bus.busy), 32'd0);
    bus.frame_clk = 1'b0;
    @(negedge Clk);
    model_frame(scr);
    push_model();
    verify_slots(tag);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    bus.frame_clk  = 1'b0;
    bus.scroll_amt = 4'd0;
    bus.DrawX      = '0;
    bus.DrawY      = '0;
    bus.BallX      = '0;
    bus.BallY      = '0;
    bus.Ball_size  = '0;
    bus.dbg_idx    = '0;

    repeat (3) @(negedge Clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.frame_done), 32'd0);
    check("rst_state", 32'(bus.state), 32'(IDLE));
    check("rst_lfsr", 32'(bus.lfsr), 32'hACE1);
    model_reset();
    push_model();
    verify_slots("rst");
    @(negedge Clk);
    Reset = 1'b0;

    // Pixel and landing flags on the start layout.
    pix(32, 15, 1'b1, "on_32_15");
    pix(52, 19, 1'b1, "on_52_19");
    pix(53, 15, 1'b0, "on_53_15");
    pix(32, 20, 1'b0, "on_32_20");
    ball(0, 0, 0, 1'b0, "land_origin");
    ball(100, 61, 10, 1'b1, "land_b71");
    ball(100, 64, 10, 1'b1, "land_b74");
    ball(100, 65, 10, 1'b0, "land_b75");
    ball(125, 61, 10, 1'b0, "land_x125");

    repeat (5) @(negedge Clk);
    check("lfsr_model", 32'(bus.lfsr), 32'(m_lfsr));

    // Frame 1: plain shift, nothing wraps.
    run_frame(4'd10, 1'b0, "f1");
    pix(32, 25, 1'b1, "f1_on_32_25");
    pix(32, 15, 1'b0, "f1_on_32_15");

    // Frame 2: slot 15 wraps to the top with a fresh X.
    run_frame(4'd10, 1'b0, "f2");
    bus.dbg_idx = 4'd15;
    #1;
    check("f2_wrap_y15", 32'(bus.dbg_y), 32'd5);
    check("f2_wrap_x15_range",
          32'((bus.dbg_x >= 10'd32) && (bus.dbg_x <= 10'd543)), 32'd1);

    // Frame 3: second request and scroll change inside the sweep are ignored.
    run_frame(4'd5, 1'b1, "f3");

    // Reset part way through a sweep.
    @(negedge Clk);
    bus.scroll_amt = 4'd3;
    bus.frame_clk  = 1'b1;
    lat = 0;
    do begin
      @(negedge Clk);
      lat++;
    end while (!bus.busy && lat < 20);
    check("rs_busy_latency", 32'(lat), 32'd3);
    repeat (7) @(negedge Clk);
    bus.frame_clk = 1'b0;
    Reset = 1'b1;
    @(negedge Clk);
    check("rs_busy", 32'(bus.busy), 32'd0);
    check("rs_state", 32'(bus.state), 32'(IDLE));
    check("rs_lfsr", 32'(bus.lfsr), 32'hACE1);
    model_reset();
    push_model();
    verify_slots("rs");
    @(negedge Clk);
    Reset = 1'b0;
    repeat (4) @(negedge Clk);
    run_frame(4'd7, 1'b0, "f4");
    check("f4_lfsr_model", 32'(bus.lfsr), 32'(m_lfsr));
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
